// File: rtl/seq_pattern_detector_if.sv
// Serial data, configuration and match/status bundle for seq_pattern_detector.
// Pure wiring; no latency of its own.
// No backpressure: din_valid only qualifies din, and the detector never stalls the source.
interface seq_pattern_detector_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               din;
    logic               din_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               clear_count;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;
    logic [LEN_W-1:0]   fill;

    // Source side: drives serial data and configuration, observes the results.
    modport master (
        output din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clear_count,
        input  match, match_count, count_sat, fill
    );

    // Detector side.
    modport slave (
        input  din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clear_count,
        output match, match_count, count_sat, fill
    );
endinterface

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial bit-pattern detector with overlap mode and saturating match counter.
// Latency: match is registered and pulses the cycle after the edge that samples the final pattern bit.
// No backpressure: every valid bit is consumed on arrival; cfg_load takes priority and discards din.
module seq_pattern_detector #(
    parameter int                 MAX_LEN         = 8,
    parameter int                 CNT_W           = 16,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'('b110),
    parameter int                 DEFAULT_LEN     = 3,
    parameter bit                 DEFAULT_OVERLAP = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_pattern_detector_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    // Only MAX_LEN-1 history bits are kept: the candidate is {history, din}, so the oldest
    // bit of a full MAX_LEN window would never take part in a comparison.
    logic [MAX_LEN-2:0] hist_q,    hist_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    logic               overlap_q, overlap_d;
    logic [LEN_W-1:0]   fill_q,    fill_d;
    logic               match_q,   match_d;
    logic [CNT_W-1:0]   count_q,   count_d;

    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   cfg_len_clamped;
    logic               fill_ok;
    logic               hit;

    // Candidate window, length mask and the match decision for the current sample.
    always_comb begin
        cand     = {hist_q, bus.din};
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
        fill_ok  = ({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_q};
        hit      = bus.din_valid && !bus.cfg_load && fill_ok
                   && (((cand ^ pattern_q) & len_mask) == '0);
        fill_inc = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);

        if (bus.cfg_len == '0) begin
            cfg_len_clamped = LEN_W'(1);
        end else if (bus.cfg_len > LEN_W'(MAX_LEN)) begin
            cfg_len_clamped = LEN_W'(MAX_LEN);
        end else begin
            cfg_len_clamped = bus.cfg_len;
        end
    end

    // Next-state: configuration load, history shift, fill tracking, match pulse and counter.
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        count_d   = count_q;

        if (bus.cfg_load) begin
            pattern_d = bus.cfg_pattern;
            len_d     = cfg_len_clamped;
            overlap_d = bus.cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
        end else if (bus.din_valid) begin
            hist_d = cand[MAX_LEN-2:0];
            fill_d = fill_inc;
            if (hit) begin
                match_d = 1'b1;
                // Non-overlapping mode restarts the count so the next match needs len fresh bits.
                if (!overlap_q) begin
                    fill_d = '0;
                end
            end
        end

        // A coincident clear beats the increment; the match pulse itself is unaffected.
        if (bus.clear_count) begin
            count_d = '0;
        end else if (match_d && !(&count_q)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset back to the default configuration.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= DEFAULT_PATTERN;
            len_q     <= LEN_W'(DEFAULT_LEN);
            overlap_q <= DEFAULT_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            count_q   <= count_d;
        end
    end

    assign bus.match       = match_q;
    assign bus.match_count = count_q;
    assign bus.count_sat   = &count_q;
    assign bus.fill        = fill_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector (MAX_LEN 8, CNT_W 4).
// Directed scenarios against fixed expectations, then randomized traffic against a queue model.
// The model keeps the bits seen since the last restart and tests the pattern on the queue tail.
module tb_seq_pattern_detector;
    logic clk = 1'b0;
    logic reset = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    seq_pattern_detector_if #(.MAX_LEN(8), .CNT_W(4)) bus ();

    seq_pattern_detector #(.MAX_LEN(8), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         seen[$];
    bit         m_match;
    int         m_cnt;
    int         m_fill;

    task automatic model_defaults();
        m_pat   = 8'b110;
        m_len   = 3;
        m_ovl   = 1'b1;
        seen.delete();
        m_match = 1'b0;
        m_cnt   = 0;
        m_fill  = 0;
    endtask

    // One clock: drive inputs, advance the model on the edge, settle past the edge.
    task automatic step(input logic d, input logic v, input logic ld, input logic [7:0] pat,
                        input int len, input logic ovl, input logic clr);
        int sz;
        bit hit;
        bus.din         = d;
        bus.din_valid   = v;
        bus.cfg_load    = ld;
        bus.cfg_pattern = pat;
        bus.cfg_len     = 4'(len);
        bus.cfg_overlap = ovl;
        bus.clear_count = clr;
        @(posedge clk);
        m_match = 1'b0;
        if (ld) begin
            m_pat = pat;
            m_len = (len < 1) ? 1 : (len > 8) ? 8 : len;
            m_ovl = ovl;
            seen.delete();
        end else if (v) begin
            seen.push_back(d);
            if (seen.size() > 32) void'(seen.pop_front());
            sz  = seen.size();
            hit = (sz >= m_len);
            for (int k = 0; k < m_len; k++) begin
                if (hit && (seen[sz-1-k] != m_pat[k])) hit = 1'b0;
            end
            if (hit) begin
                m_match = 1'b1;
                if (!m_ovl) seen.delete();
            end
        end
        if (clr) m_cnt = 0;
        else if (m_match && m_cnt < 15) m_cnt++;
        m_fill = (seen.size() < m_len) ? seen.size() : m_len;
        #1;
    endtask

    task automatic feed(input logic d);
        step(d, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic d);
        step(d, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] pat, input int len, input logic ovl, input logic d);
        step(d, 1'b1, 1'b1, pat, len, ovl, 1'b0);
    endtask

    task automatic do_reset();
        bus.din         = 1'b1;
        bus.din_valid   = 1'b1;
        bus.cfg_load    = 1'b0;
        bus.cfg_pattern = 8'h00;
        bus.cfg_len     = 4'd0;
        bus.cfg_overlap = 1'b0;
        bus.clear_count = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        model_defaults();
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bus.match !== 1'b0) begin
            miscompares++; $display("FAIL reset_match got=%b want=0", bus.match);
        end
        vectors++;
        if (bus.match_count !== 4'd0 || bus.count_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_count got=%0d sat=%b want=0 sat=0", bus.match_count, bus.count_sat);
        end
        vectors++;
        if (bus.fill !== 4'd0) begin
            miscompares++; $display("FAIL reset_fill got=%0d want=0", bus.fill);
        end
    endtask

    task automatic test_default_stream();
        logic seq  [7] = '{0, 1, 1, 0, 1, 1, 0};
        logic expm [7] = '{0, 0, 0, 1, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            feed(seq[i]);
            vectors++;
            if (bus.match !== expm[i]) begin
                miscompares++; $display("FAIL default_match[%0d] got=%b want=%b", i, bus.match, expm[i]);
            end
            if (expm[i]) begin
                vectors++;
                if (bus.fill !== 4'd3) begin
                    miscompares++; $display("FAIL default_fill[%0d] got=%0d want=3", i, bus.fill);
                end
            end
        end
        vectors++;
        if (bus.match_count !== 4'd2) begin
            miscompares++; $display("FAIL default_count got=%0d want=2", bus.match_count);
        end
    endtask

    task automatic test_overlap_modes();
        logic seq   [7] = '{1, 0, 1, 0, 1, 0, 1};
        logic exp_o [7] = '{0, 0, 0, 1, 0, 1, 0};
        logic exp_n [7] = '{0, 0, 0, 1, 0, 0, 0};
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            load(8'b1010, 4, (pass == 0), 1'b1);
            vectors++;
            if (bus.match !== 1'b0 || bus.fill !== 4'd0) begin
                miscompares++;
                $display("FAIL load_state match=%b fill=%0d want 0/0", bus.match, bus.fill);
            end
            for (int i = 0; i < 7; i++) begin
                feed(seq[i]);
                vectors++;
                if (bus.match !== ((pass == 0) ? exp_o[i] : exp_n[i])) begin
                    miscompares++;
                    $display("FAIL overlap%0d_match[%0d] got=%b want=%b", 1 - pass, i, bus.match,
                             (pass == 0) ? exp_o[i] : exp_n[i]);
                end
            end
        end
        vectors++;
        if (bus.match_count !== 4'd3) begin
            miscompares++; $display("FAIL overlap_count got=%0d want=3", bus.match_count);
        end
    endtask

    task automatic test_gaps();
        logic seq [3] = '{1, 1, 0};
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            feed(seq[i]);
            vectors++;
            if (bus.match !== (i == 2)) begin
                miscompares++; $display("FAIL gap_valid[%0d] got=%b want=%b", i, bus.match, (i == 2));
            end
            if (bus.match === 1'b1) pulses++;
            for (int g = 0; g < 3; g++) begin
                idle(g[0] ^ seq[i]);
                vectors++;
                if (bus.match !== 1'b0) begin
                    miscompares++; $display("FAIL gap_idle[%0d.%0d] got=%b want=0", i, g, bus.match);
                end
                if (bus.match === 1'b1) pulses++;
            end
        end
        vectors++;
        if (pulses != 1 || bus.fill !== 4'd3) begin
            miscompares++; $display("FAIL gap_pulses got=%0d fill=%0d want=1 fill=3", pulses, bus.fill);
        end
    endtask

    task automatic test_load_mid();
        logic seq  [3] = '{1, 0, 1};
        logic expm [3] = '{0, 0, 1};
        do_reset();
        feed(1); feed(1); feed(0);
        feed(1); feed(1);
        load(8'b01, 2, 1'b1, 1'b0);
        vectors++;
        if (bus.match !== 1'b0) begin
            miscompares++; $display("FAIL loadmid_load got=%b want=0", bus.match);
        end
        for (int i = 0; i < 3; i++) begin
            feed(seq[i]);
            vectors++;
            if (bus.match !== expm[i]) begin
                miscompares++; $display("FAIL loadmid_match[%0d] got=%b want=%b", i, bus.match, expm[i]);
            end
        end
        vectors++;
        if (bus.match_count !== 4'd2) begin
            miscompares++; $display("FAIL loadmid_count got=%0d want=2", bus.match_count);
        end
    endtask

    task automatic test_saturation();
        logic seq  [4] = '{1, 1, 0, 1};
        int want;
        do_reset();
        load(8'b1, 1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            feed(1);
            want = (i + 1 > 15) ? 15 : i + 1;
            vectors++;
            if (bus.match !== 1'b1 || bus.match_count !== 4'(want) || bus.count_sat !== (want == 15)) begin
                miscompares++;
                $display("FAIL sat[%0d] match=%b count=%0d sat=%b want 1/%0d/%b", i, bus.match,
                         bus.match_count, bus.count_sat, want, (want == 15));
            end
        end
        step(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1);
        vectors++;
        if (bus.match !== 1'b1 || bus.match_count !== 4'd0 || bus.count_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_on_match match=%b count=%0d sat=%b want 1/0/0", bus.match,
                     bus.match_count, bus.count_sat);
        end
        load(8'b1, 1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            feed(seq[i]);
            vectors++;
            if (bus.match !== seq[i]) begin
                miscompares++; $display("FAIL len1_nonovl[%0d] got=%b want=%b", i, bus.match, seq[i]);
            end
        end
    endtask

    task automatic test_reset_and_clamp();
        logic s0 [3] = '{1, 0, 1};
        logic s8 [8] = '{1, 0, 1, 1, 0, 0, 1, 1};
        do_reset();
        feed(1); feed(1);
        do_reset();
        feed(0);
        vectors++;
        if (bus.match !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid got=%b want=0", bus.match);
        end
        load(8'b01, 2, 1'b1, 1'b0);
        do_reset();
        feed(1); feed(1); feed(0);
        vectors++;
        if (bus.match !== 1'b1) begin
            miscompares++; $display("FAIL reset_reverts got=%b want=1", bus.match);
        end
        load(8'b1, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            feed(s0[i]);
            vectors++;
            if (bus.match !== s0[i]) begin
                miscompares++; $display("FAIL clamp_len0[%0d] got=%b want=%b", i, bus.match, s0[i]);
            end
        end
        load(8'b10110011, 9, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            feed(s8[i]);
            vectors++;
            if (bus.match !== (i == 7)) begin
                miscompares++; $display("FAIL clamp_len9[%0d] got=%b want=%b", i, bus.match, (i == 7));
            end
        end
        vectors++;
        if (bus.fill !== 4'd8) begin
            miscompares++; $display("FAIL clamp_len9_fill got=%0d want=8", bus.fill);
        end
    endtask

    task automatic test_random();
        int r;
        int len;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 299);
            if (r == 0) begin
                do_reset();
            end else if (r < 9) begin
                len = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 9) : $urandom_range(1, 3);
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                     8'($urandom_range(0, 255)), len, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0, 8'h00, 0, 1'b0,
                     ($urandom_range(0, 59) == 0));
            end
            vectors++;
            if (bus.match !== m_match) begin
                miscompares++; $display("FAIL rand_match[%0d] got=%b want=%b", i, bus.match, m_match);
            end
            vectors++;
            if (bus.match_count !== 4'(m_cnt)) begin
                miscompares++; $display("FAIL rand_count[%0d] got=%0d want=%0d", i, bus.match_count, m_cnt);
            end
            vectors++;
            if (bus.count_sat !== (m_cnt == 15)) begin
                miscompares++; $display("FAIL rand_sat[%0d] got=%b want=%b", i, bus.count_sat, (m_cnt == 15));
            end
            vectors++;
            if (bus.fill !== 4'(m_fill)) begin
                miscompares++; $display("FAIL rand_fill[%0d] got=%0d want=%0d", i, bus.fill, m_fill);
            end
        end
    endtask

    initial begin
        model_defaults();
        test_reset();
        test_default_stream();
        test_overlap_modes();
        test_gaps();
        test_load_mid();
        test_saturation();
        test_reset_and_clamp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
